hdma_engine: RTL and testbench
==============================

Name: hdma_engine

Overview:
- Parametrised successor to the single-mode OAM DMA unit.
- Moves fixed-size blocks from an arbitrary source address into a VRAM-window destination.
- Two modes:
  - general (all blocks back-to-back while the CPU is stalled);
  - hblank (one block per rising edge of hblank).
- Sits beside the DMA, decode and VRAM-interface blocks, between the CPU register bus and the VRAM/external memory arbiter.

Parameters:
- ADDR_W, 16, source/destination address width
- LEN_W, 7, length field width; 1..2^LEN_W blocks
- BLK_LOG2, 4, log2 of bytes per block (16)
- DST_BASE, 16'h8000, destination window base
- DST_W, 13, destination window offset width (window 0x8000-0x9FFF)

Ports:
- clk1  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- reg_wr  in  1  register write strobe, one cycle
- reg_sel  in  3  0=src hi, 1=src lo, 2=dst hi, 3=dst lo, 4=control
- reg_wdata  in  8  register write data
- status  out  8  bit7=idle; bits LEN_W-1:0 = remaining blocks minus 1
- hblank  in  1  hblank level from the PPU
- mem_req  out  1  memory cycle valid
- mem_we  out  1  1=write cycle, 0=read cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid in the same cycle as a read request
- cpu_stall  out  1  halts the CPU while bytes are moving
- dma_done  out  1  one-cycle completion pulse (HDMA_IRQ_EN only; otherwise tied 0)

Behaviour:
- Reset values:
  - status=8'hFF; all mem_* outputs 0; cpu_stall=0; dma_done=0.
  - src, dst and remaining registers cleared; state IDLE.
- Address registers:
  - src low nibble (BLK_LOG2 bits) forced to 0.
  - Effective destination = DST_BASE | {dst[DST_W-1:BLK_LOG2], BLK_LOG2'b0}.
- Source wrap: src increments modulo 2^ADDR_W.
- Destination wrap: dst offset increments modulo 2^DST_W and never leaves the window.
- Control write (reg_sel=4):
  - bit7=0 in IDLE: start general mode.
  - bit7=1 in IDLE: start hblank mode (ARMED).
  - bit7=0 while ARMED: cancel; return to IDLE, remaining kept, status bit7=1.
  - bits LEN_W-1:0 give remaining = blocks-1.
- States: IDLE, ARMED, RD, WR.
  - IDLE -> RD on a general start. IDLE -> ARMED on an hblank start.
  - ARMED -> RD on a rising edge of hblank (registered previous value). If hblank is already 1 in the cycle the start is written, the first block starts on the next cycle.
  - RD: mem_req=1, mem_we=0, mem_addr=src; capture mem_rdata; -> WR.
  - WR: mem_req=1, mem_we=1, mem_addr=dst, mem_wdata=captured byte; increment src and dst.
    - If the byte counter < 2^BLK_LOG2-1: -> RD.
    - Otherwise (block end), when remaining==0: -> IDLE, status=8'hFF.
    - Otherwise decrement remaining, then -> RD in general mode, or -> ARMED in hblank mode.
- Timing:
  - 2 cycles per byte; one block = 2^(BLK_LOG2+1) cycles (32 by default).
  - A general transfer of N blocks takes N*32 cycles with no gaps.
- cpu_stall=1 exactly while the state is RD or WR.
- Register writes during RD/WR are ignored, so there is no cancel mid-block.
- src/dst writes in ARMED are accepted and apply to the next block.
- Status is combinational from the state and remaining registers.
- Asserting nreset mid-transfer aborts immediately; no partial-block completion.

Optional Feature:
- Macro: HDMA_IRQ_EN.
  - Defined: dma_done pulses high for 1 cycle in the cycle after the final WR. A cancel produces no pulse.
  - Undefined: dma_done is constant 0 and the pulse logic is absent.

Decomposition:
- Shared package hdma_pkg holds:
  - state enum (IDLE, ARMED, RD, WR);
  - reg_sel codes (REG_SRC_HI .. REG_CTRL);
  - the status idle-bit index.
- One sub-module, hdma_addr_gen: holds and increments the src/dst counters with the masking and wrap rules.
- The FSM stays in hdma_engine.

Test Plan:
1. General mode:
   - Stimulus: src=0xC000, dst=0x8000, control=0x01.
   - Response: 64 busy cycles with cpu_stall=1; read 0xC000..0xC01F and write 0x8000..0x801F alternately; status returns to 0xFF.
2. Hblank mode:
   - Stimulus: control=0x82, then three hblank pulses 100 cycles apart.
   - Response: one 16-byte block per rising edge; status 0x02 -> 0x01 -> 0x00 -> 0xFF; no stall between pulses.
3. Cancel:
   - Stimulus: control=0x85; after one block, write control=0x00.
   - Response: state IDLE; status=0x84 (idle bit set, remaining 4); later hblank edges cause no mem_req.
4. Wrap:
   - Stimulus: src=0xFFF0, dst=0x9FF0, control=0x01.
   - Response: the second block reads 0x0000 and writes 0x8000.
5. Start inside hblank plus reset abort:
   - Stimulus: hblank=1, then write control=0x80.
   - Response: RD begins on the next cycle.
   - Stimulus: repeat the start and assert nreset mid-block.
   - Response: all outputs return to their reset values in the same cycle.
6. HDMA_IRQ_EN:
   - Stimulus: the scenario-1 transfer.
   - Response: dma_done high for exactly 1 cycle after the last write; 0 in a build without the macro.

Source files
------------

// File: rtl/hdma_pkg.sv
// hdma_pkg: shared state encoding, register-select codes and status layout for the HDMA engine.
// Imported by hdma_engine and hdma_addr_gen.
package hdma_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, RD, WR} state_e;
    localparam logic [2:0] REG_SRC_HI = 3'd0;
    localparam logic [2:0] REG_SRC_LO = 3'd1;
    localparam logic [2:0] REG_DST_HI = 3'd2;
    localparam logic [2:0] REG_DST_LO = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam int STATUS_IDLE_BIT = 7;
endpackage

// File: rtl/hdma_addr_gen.sv
// hdma_addr_gen: source and destination counters for the HDMA engine.
// Writes land block-aligned; source wraps over the full space, destination stays inside the VRAM window.
module hdma_addr_gen
    import hdma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int BLK_LOG2 = 4,
    parameter int DST_W = 13,
    parameter logic [ADDR_W-1:0] DST_BASE = 16'h8000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [2:0]        sel_i,
    input  logic [7:0]        wdata_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] src_o,
    output logic [ADDR_W-1:0] dst_o
);
    logic [ADDR_W-1:0] src_q;
    logic [DST_W-1:0]  dst_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            dst_q <= '0;
        end else if (inc_i) begin
            src_q <= src_q + ADDR_W'(1);
            dst_q <= dst_q + DST_W'(1);
        end else if (wr_i) begin
            case (sel_i)
                REG_SRC_HI: src_q[ADDR_W-1:8] <= wdata_i[ADDR_W-9:0];
                REG_SRC_LO: src_q[7:0] <= {wdata_i[7:BLK_LOG2], {BLK_LOG2{1'b0}}};
                REG_DST_HI: dst_q[DST_W-1:8] <= wdata_i[DST_W-9:0];
                REG_DST_LO: dst_q[7:0] <= {wdata_i[7:BLK_LOG2], {BLK_LOG2{1'b0}}};
                default: ;
            endcase
        end
    end
    assign src_o = src_q;
    assign dst_o = DST_BASE | ADDR_W'(dst_q);
endmodule

// File: rtl/hdma_engine.sv
// hdma_engine: block DMA into the VRAM window, general (CPU stalled) or one block per hblank rising edge.
// Optional completion pulse on dma_done when built with HDMA_IRQ_EN.
module hdma_engine
    import hdma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W = 7,
    parameter int BLK_LOG2 = 4,
    parameter logic [ADDR_W-1:0] DST_BASE = 16'h8000,
    parameter int DST_W = 13
) (
    input  logic              clk1,
    input  logic              nreset,
    input  logic              reg_wr,
    input  logic [2:0]        reg_sel,
    input  logic [7:0]        reg_wdata,
    output logic [7:0]        status,
    input  logic              hblank,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_stall,
    output logic              dma_done
);
    state_e              state_q;
    logic [LEN_W-1:0]    rem_q;
    logic [BLK_LOG2-1:0] cnt_q;
    logic [7:0]          data_q;
    logic                hb_q, hmode_q, cancel_q;
    logic [ADDR_W-1:0]   src, dst;
    logic                reg_ok, ctrl_wr, last_wr;

    assign cpu_stall = (state_q == RD) || (state_q == WR);
    assign reg_ok    = reg_wr && !cpu_stall;
    assign ctrl_wr   = reg_ok && (reg_sel == REG_CTRL);
    assign last_wr   = (state_q == WR) && (cnt_q == '1) && (rem_q == '0);

    hdma_addr_gen #(
        .ADDR_W(ADDR_W), .BLK_LOG2(BLK_LOG2), .DST_W(DST_W), .DST_BASE(DST_BASE)
    ) u_addr (
        .clk_i(clk1), .rst_ni(nreset), .wr_i(reg_ok), .sel_i(reg_sel),
        .wdata_i(reg_wdata), .inc_i(state_q == WR), .src_o(src), .dst_o(dst)
    );

    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            hb_q     <= 1'b0;
            hmode_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            hb_q <= hblank;
            case (state_q)
                IDLE: if (ctrl_wr) begin
                    rem_q    <= reg_wdata[LEN_W-1:0];
                    hmode_q  <= reg_wdata[7];
                    cancel_q <= 1'b0;
                    // a start written while hblank is already high runs its first block at once
                    state_q  <= (reg_wdata[7] && !hblank) ? ARMED : RD;
                end
                ARMED: if (ctrl_wr && !reg_wdata[7]) begin
                    state_q  <= IDLE;
                    cancel_q <= 1'b1;
                end else if (hblank && !hb_q) begin
                    state_q <= RD;
                end
                RD: begin
                    data_q  <= mem_rdata;
                    state_q <= WR;
                end
                WR: begin
                    cnt_q <= cnt_q + BLK_LOG2'(1);
                    if (cnt_q != '1) begin
                        state_q <= RD;
                    end else if (rem_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q   <= rem_q - LEN_W'(1);
                        state_q <= hmode_q ? ARMED : RD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = cpu_stall;
    assign mem_we    = state_q == WR;
    assign mem_addr  = (state_q == RD) ? src : (state_q == WR) ? dst : '0;
    assign mem_wdata = (state_q == WR) ? data_q : 8'h00;

    // idle after a cancel still reports the kept remaining count
    always_comb begin
        status = 8'(rem_q);
        status[STATUS_IDLE_BIT] = state_q == IDLE;
        status = (state_q == IDLE && !cancel_q) ? 8'hFF : status;
    end

`ifdef HDMA_IRQ_EN
    logic done_q;
    always_ff @(posedge clk1 or negedge nreset) begin
        if (!nreset) done_q <= 1'b0;
        else         done_q <= last_wr;
    end
    assign dma_done = done_q;
`else
    logic unused_last;
    assign unused_last = last_wr;
    assign dma_done = 1'b0;
`endif
endmodule

// File: tb/tb_hdma_engine.sv
// tb_hdma_engine: directed checks of general/hblank transfers, cancel, wrap, start-in-hblank and reset abort.
// Memory model returns addr[7:0]^addr[15:8]^0x5A for every read.
module tb_hdma_engine;
    logic        clk1 = 1'b0, nreset = 1'b0, reg_wr = 1'b0, hblank = 1'b0;
    logic [2:0]  reg_sel = 3'd0;
    logic [7:0]  reg_wdata = 8'h00, status, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, cpu_stall, dma_done;
    logic [15:0] mem_addr;
    int          checks = 0, failures = 0;
    logic        exp_done;

    hdma_engine dut (
        .clk1(clk1), .nreset(nreset), .reg_wr(reg_wr), .reg_sel(reg_sel),
        .reg_wdata(reg_wdata), .status(status), .hblank(hblank), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .dma_done(dma_done)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [7:0] f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign mem_rdata = f(mem_addr);

    task automatic tick;
        @(negedge clk1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
        reg_wr = 1'b1;
        reg_sel = sel;
        reg_wdata = d;
        tick;
        reg_wr = 1'b0;
    endtask

    task automatic blk(input logic [15:0] s, input logic [12:0] o);
        logic [15:0] a, d;
        logic [12:0] off;
        for (int i = 0; i < 16; i++) begin
            a = s + 16'(i);
            off = o + 13'(i);
            d = 16'h8000 | {3'b000, off};
            chk("rd", {mem_req, mem_we, cpu_stall, mem_addr}, {3'b101, a});
            tick;
            chk("wr", {mem_req, mem_we, cpu_stall, mem_addr, mem_wdata}, {3'b111, d, f(a)});
            tick;
        end
    endtask

    task automatic idle_chk(input string tag, input logic [7:0] st);
        chk(tag, {status, mem_req, mem_we, cpu_stall}, {st, 3'b000});
    endtask

    initial begin
`ifdef HDMA_IRQ_EN
        exp_done = 1'b1;
`else
        exp_done = 1'b0;
`endif
        tick; tick;
        chk("reset", {status, mem_req, mem_we, mem_addr, mem_wdata, cpu_stall, dma_done},
            {8'hFF, 2'b00, 16'h0000, 8'h00, 2'b00});
        nreset = 1'b1;
        tick;

        // general mode, two blocks
        wr_reg(3'd0, 8'hC0); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h80); wr_reg(3'd3, 8'h00);
        idle_chk("pre_gen", 8'hFF);
        wr_reg(3'd4, 8'h01);
        chk("gen_status0", status, 8'h01);
        blk(16'hC000, 13'h0000);
        chk("gen_status1", status, 8'h00);
        blk(16'hC010, 13'h0010);
        idle_chk("gen_end", 8'hFF);
        chk("gen_done", dma_done, exp_done);
        tick;
        chk("gen_done_clr", dma_done, 1'b0);

        // hblank mode, three blocks; src low nibble write is masked
        wr_reg(3'd0, 8'h12); wr_reg(3'd1, 8'h37); wr_reg(3'd2, 8'h01); wr_reg(3'd3, 8'h45);
        wr_reg(3'd4, 8'h82);
        idle_chk("armed", 8'h02);
        for (int k = 0; k < 3; k++) begin
            hblank = 1'b1;
            tick;
            chk("hb_status", status, 32'(8'h02 - 8'(k)));
            blk(16'h1230 + 16'(16 * k), 13'h0140 + 13'(16 * k));
            idle_chk("hb_after", (k == 2) ? 8'hFF : 8'(8'h81 - 8'(k)) & 8'h7F);
            hblank = 1'b0;
            repeat (60) tick;
            idle_chk("hb_gap", (k == 2) ? 8'hFF : 8'(8'h01 - 8'(k)));
        end

        // cancel after one block
        wr_reg(3'd0, 8'h40); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h00); wr_reg(3'd3, 8'h00);
        wr_reg(3'd4, 8'h85);
        idle_chk("cancel_armed", 8'h05);
        hblank = 1'b1;
        tick;
        blk(16'h4000, 13'h0000);
        hblank = 1'b0;
        tick;
        idle_chk("cancel_pre", 8'h04);
        wr_reg(3'd4, 8'h00);
        idle_chk("cancel_post", 8'h84);
        hblank = 1'b1;
        tick; tick;
        idle_chk("cancel_hb", 8'h84);
        hblank = 1'b0;
        tick;
        wr_reg(3'd4, 8'h00);
        chk("cancel_nodone", dma_done, 1'b0);
        blk(16'h4010, 13'h0010);
        idle_chk("cancel_restart_end", 8'hFF);
        tick;

        // source and destination wrap
        wr_reg(3'd0, 8'hFF); wr_reg(3'd1, 8'hF0); wr_reg(3'd2, 8'h9F); wr_reg(3'd3, 8'hF0);
        wr_reg(3'd4, 8'h01);
        blk(16'hFFF0, 13'h1FF0);
        blk(16'h0000, 13'h0000);
        idle_chk("wrap_end", 8'hFF);
        tick;

        // start while hblank already high
        hblank = 1'b1;
        tick;
        wr_reg(3'd4, 8'h80);
        blk(16'h0010, 13'h0010);
        idle_chk("inhb_end", 8'hFF);
        chk("inhb_done", dma_done, exp_done);
        tick;

        // reset abort mid-block
        wr_reg(3'd4, 8'h80);
        chk("abort_rd", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0020});
        repeat (5) tick;
        #2 nreset = 1'b0;
        #1;
        chk("abort_reset", {status, mem_req, mem_we, mem_addr, mem_wdata, cpu_stall, dma_done},
            {8'hFF, 2'b00, 16'h0000, 8'h00, 2'b00});
        tick;
        nreset = 1'b1;
        hblank = 1'b0;
        tick;
        wr_reg(3'd4, 8'h00);
        blk(16'h0000, 13'h0000);
        idle_chk("post_reset_end", 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
